// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes and the pipeline-control FSM state type.
package riscv_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] IMM_OP = 7'b0010011;
    localparam logic [6:0] REG_OP = 7'b0110011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the rd of a LOAD in EX.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_ID,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic [6:0] opcode_EX,
    input  logic [4:0] rd_EX,
    output logic       use1,
    output logic       use2,
    output logic       loaduse
);

    // Source-register usage by ID opcode and the resulting hazard
    always_comb begin
        use1    = !((opcode_ID == LUI) || (opcode_ID == AUIPC) || (opcode_ID == JAL));
        use2    = (opcode_ID == REG_OP) || (opcode_ID == BRANCH) || (opcode_ID == STORE);
        loaduse = (opcode_EX == LOAD) && (rd_EX != 5'd0) &&
                  ((use1 && (rs1_ID == rd_EX)) || (use2 && (rs2_ID == rd_EX)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stage enable/flush sequencer for the 5-stage RV32I core.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode_ID,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic [6:0]  opcode_EX,
    input  logic [4:0]  rd_EX,
    input  logic        res_EX_lsb,
    input  logic        dmem_req_MEM,
    input  logic        dmem_ready,
    output logic        en_PC,
    output logic        en_IF_ID,
    output logic        en_ID_EX,
    output logic        en_EX_MEM,
    output logic        en_MEM_WB,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        flush_MEM_WB,
    output logic        redirect,
    output logic        mem_timeout,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

    ctrl_state_t    state_r;
    ctrl_state_t    next_state_s;
    logic           squash_r;
    logic           squash_next_s;
    logic [WCW-1:0] wait_cnt_r;
    logic [WCW-1:0] wait_inc_s;
    logic           mem_timeout_r;
    logic           memwait_s;
    logic           taken_s;
    logic           use1_s;
    logic           use2_s;
    logic           loaduse_s;

    load_use_detect u_lud (
        .opcode_ID (opcode_ID),
        .rs1_ID    (rs1_ID),
        .rs2_ID    (rs2_ID),
        .opcode_EX (opcode_EX),
        .rd_EX     (rd_EX),
        .use1      (use1_s),
        .use2      (use2_s),
        .loaduse   (loaduse_s)
    );

    // Hazard qualification and saturating wait-count increment
    always_comb begin
        memwait_s = dmem_req_MEM && !dmem_ready;
        taken_s   = ((opcode_EX == BRANCH) && res_EX_lsb) ||
                    (opcode_EX == JAL) || (opcode_EX == JALR);
        if (wait_cnt_r == WAIT_MAX) begin
            wait_inc_s = WAIT_MAX;
        end else begin
            wait_inc_s = wait_cnt_r + WCW'(1);
        end
    end

    // Stage enables, flushes, redirect and next-state selection (memwait > taken > loaduse)
    always_comb begin
        en_PC         = 1'b1;
        en_IF_ID      = 1'b1;
        en_ID_EX      = 1'b1;
        en_EX_MEM     = 1'b1;
        en_MEM_WB     = 1'b1;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_MEM_WB  = 1'b0;
        redirect      = 1'b0;
        next_state_s  = RUN;
        squash_next_s = 1'b0;
        if (!reset_n) begin
            en_PC        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            en_MEM_WB    = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (memwait_s) begin
            en_PC         = 1'b0;
            en_IF_ID      = 1'b0;
            en_ID_EX      = 1'b0;
            en_EX_MEM     = 1'b0;
            flush_MEM_WB  = 1'b1;
            next_state_s  = MEM_WAIT;
            // A squash interrupted by the wait is remembered for after release
            squash_next_s = squash_r || (state_r == REDIRECT);
        end else if (taken_s) begin
            redirect     = 1'b1;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            next_state_s = REDIRECT;
        end else begin
            if (state_r == REDIRECT) begin
                flush_IF_ID = 1'b1;
            end else if (loaduse_s) begin
                en_PC       = 1'b0;
                en_IF_ID    = 1'b0;
                flush_ID_EX = 1'b1;
            end else begin
                flush_IF_ID = 1'b0;
            end
            if ((state_r == MEM_WAIT) && squash_r) begin
                next_state_s = REDIRECT;
            end else begin
                next_state_s = RUN;
            end
        end
    end

    // FSM state, pending squash, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= RUN;
            squash_r      <= 1'b0;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            squash_r <= squash_next_s;
            if (memwait_s) begin
                wait_cnt_r <= wait_inc_s;
                if (wait_inc_s == WAIT_MAX) begin
                    mem_timeout_r <= 1'b1;
                end else begin
                    mem_timeout_r <= mem_timeout_r;
                end
            end else begin
                wait_cnt_r    <= '0;
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    assign mem_timeout = mem_timeout_r;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cnt_stall_r;
    logic [31:0] cnt_flush_r;

    // Stall-cycle and redirect counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_stall_r <= 32'd0;
            cnt_flush_r <= 32'd0;
        end else begin
            if (!en_PC) begin
                cnt_stall_r <= cnt_stall_r + 32'd1;
            end else begin
                cnt_stall_r <= cnt_stall_r;
            end
            if (redirect) begin
                cnt_flush_r <= cnt_flush_r + 32'd1;
            end else begin
                cnt_flush_r <= cnt_flush_r;
            end
        end
    end

    assign cnt_stall = cnt_stall_r;
    assign cnt_flush = cnt_flush_r;
`else
    assign cnt_stall = 32'd0;
    assign cnt_flush = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan cases then random traffic vs a rule model.
module tb_pipe_hazard_ctrl;
    import riscv_pkg::*;

    localparam int MT = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode_ID, opcode_EX;
    logic [4:0]  rs1_ID, rs2_ID, rd_EX;
    logic        res_EX_lsb, dmem_req_MEM, dmem_ready;
    logic        en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, flush_MEM_WB, redirect, mem_timeout;
    logic [31:0] cnt_stall, cnt_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset_n(reset_n),
        .opcode_ID(opcode_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .opcode_EX(opcode_EX), .rd_EX(rd_EX), .res_EX_lsb(res_EX_lsb),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .en_PC(en_PC), .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX),
        .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_MEM_WB(flush_MEM_WB),
        .redirect(redirect), .mem_timeout(mem_timeout),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    // ctl = {en_PC,en_IF_ID,en_ID_EX,en_EX_MEM,en_MEM_WB,flush_IF_ID,flush_ID_EX,flush_MEM_WB,redirect}
    typedef struct packed {
        logic [8:0]  ctl;
        logic        to;
        logic [31:0] cs;
        logic [31:0] cf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Model of the rules: what happened last cycle, not an FSM encoding
    bit          last_taken, release_squash, pend, prev_wait, m_to;
    int          run_len;
    int unsigned m_stall, m_flush;

    task automatic model_step();
        exp_t e;
        bit mw, tk, u1, u2, lu, sq;
        mw = dmem_req_MEM && !dmem_ready;
        tk = (opcode_EX == BRANCH && res_EX_lsb) || opcode_EX == JAL || opcode_EX == JALR;
        u1 = !(opcode_ID == LUI || opcode_ID == AUIPC || opcode_ID == JAL);
        u2 = opcode_ID == REG_OP || opcode_ID == BRANCH || opcode_ID == STORE;
        lu = opcode_EX == LOAD && rd_EX != 5'd0 &&
             ((u1 && rs1_ID == rd_EX) || (u2 && rs2_ID == rd_EX));
        sq = last_taken || release_squash;
        e.to = m_to;
        e.cs = PERF ? m_stall : 32'd0;
        e.cf = PERF ? m_flush : 32'd0;
        if (!reset_n) begin
            e.ctl = 9'b00000_111_0;
            last_taken = 0; release_squash = 0; pend = 0; prev_wait = 0; m_to = 0;
            run_len = 0; m_stall = 0; m_flush = 0;
        end else if (mw) begin
            e.ctl = 9'b00001_001_0;
            pend = pend || sq;
            run_len = (run_len + 1 > MT) ? MT : run_len + 1;
            if (run_len == MT) m_to = 1;
            m_stall++;
            last_taken = 0; release_squash = 0; prev_wait = 1;
        end else if (tk) begin
            e.ctl = 9'b11111_110_1;
            m_flush++;
            pend = 0; last_taken = 1; release_squash = 0; prev_wait = 0; run_len = 0;
        end else begin
            if (sq) e.ctl = 9'b11111_100_0;
            else if (lu) begin e.ctl = 9'b00111_010_0; m_stall++; end
            else e.ctl = 9'b11111_000_0;
            release_squash = prev_wait && pend;
            pend = 0; last_taken = 0; prev_wait = 0; run_len = 0;
        end
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ctl", {23'd0, en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
                        flush_IF_ID, flush_ID_EX, flush_MEM_WB, redirect}, {23'd0, e.ctl});
            chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
            chk("cnt_stall", cnt_stall, e.cs);
            chk("cnt_flush", cnt_flush, e.cf);
        end
    end

    task automatic cyc(input logic rn, input logic [6:0] oid, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [6:0] oex, input logic [4:0] rd, input logic lsb,
                       input logic req, input logic rdy);
        @(posedge clk); #1;
        reset_n = rn; opcode_ID = oid; rs1_ID = r1; rs2_ID = r2;
        opcode_EX = oex; rd_EX = rd; res_EX_lsb = lsb; dmem_req_MEM = req; dmem_ready = rdy;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, IMM_OP, 5'd0, 5'd0, IMM_OP, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rst();
        cyc(1'b0, IMM_OP, 5'd0, 5'd0, IMM_OP, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, IMM_OP, REG_OP};
        reset_n = 1'b0; opcode_ID = IMM_OP; opcode_EX = IMM_OP; rs1_ID = 5'd0; rs2_ID = 5'd0;
        rd_EX = 5'd0; res_EX_lsb = 1'b0; dmem_req_MEM = 1'b0; dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        rst(); idle(2);
        // load-use on rs1, then clean cycle
        cyc(1'b1, REG_OP, 5'd5, 5'd1, LOAD, 5'd5, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, REG_OP, 5'd6, 5'd7, IMM_OP, 5'd5, 1'b0, 1'b0, 1'b1);
        // no false hazards
        cyc(1'b1, REG_OP, 5'd0, 5'd3, LOAD, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, LUI, 5'd7, 5'd7, LOAD, 5'd7, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, IMM_OP, 5'd1, 5'd7, LOAD, 5'd7, 1'b0, 1'b0, 1'b1);
        // taken and not-taken branch
        cyc(1'b1, IMM_OP, 5'd0, 5'd0, BRANCH, 5'd0, 1'b1, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, IMM_OP, 5'd0, 5'd0, BRANCH, 5'd0, 1'b0, 1'b0, 1'b1);
        // 3-cycle memory wait with load-use pending, then bubble
        rst();
        repeat (3) cyc(1'b1, REG_OP, 5'd5, 5'd2, LOAD, 5'd5, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, REG_OP, 5'd5, 5'd2, LOAD, 5'd5, 1'b0, 1'b1, 1'b1);
        idle(2);
        // timeout: sticky after ready returns, cleared by reset
        repeat (6) cyc(1'b1, IMM_OP, 5'd0, 5'd0, IMM_OP, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        rst(); idle(1);
        // reset in the middle of a wait
        repeat (2) cyc(1'b1, IMM_OP, 5'd0, 5'd0, IMM_OP, 5'd0, 1'b0, 1'b1, 1'b0);
        rst(); idle(2);
        // wait arriving in the squash cycle after a redirect
        cyc(1'b1, IMM_OP, 5'd0, 5'd0, JAL, 5'd1, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, IMM_OP, 5'd0, 5'd0, IMM_OP, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 64) != 0,
                ($urandom % 16 == 0) ? 7'($urandom) : ops[$urandom % 9],
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom % 16 == 0) ? 7'($urandom) : ops[$urandom % 9],
                5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), ($urandom % 3) != 0);
        end
        @(posedge clk); @(negedge clk); #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
